aes_inv_core_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 115 +++++++++++
 rtl/aes_key_step.sv | 36 +++
 rtl/aes_inv_core_iter.sv | 216 +++++++++++++++++++++
 tb/tb_aes_inv_core_iter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms.
// Used by the iterative decryptor and by the combinational aes_core encryptor.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_block_t;
  // Byte (col c, row r) lives at s[3-c][3-r]; a plain cast from aes_block_t keeps FIPS byte order.
  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_ADDKEY = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4,
    S_DONE   = 3'd5
  } fsm_e;

  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bit 2047-8x, i.e. index {~x, 3'b111}.
  function automatic logic [7:0] sbox(logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmulb(logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmuld(logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmule(logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic aes_block_t inv_shift_rows(aes_block_t b);
    state_t s;
    s = b;
    return {s[3][3], s[0][2], s[1][1], s[2][0],
            s[2][3], s[3][2], s[0][1], s[1][0],
            s[1][3], s[2][2], s[3][1], s[0][0],
            s[0][3], s[1][2], s[2][1], s[3][0]};
  endfunction

  function automatic aes_block_t inv_sub_bytes(aes_block_t b);
    aes_block_t o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(b[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
            gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
            gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
            gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

  function automatic aes_block_t inv_mix_columns(aes_block_t b);
    return {inv_mix_col(b[127:96]), inv_mix_col(b[95:64]),
            inv_mix_col(b[63:32]), inv_mix_col(b[31:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: forward (k_i -> k_i+1) when dir=0, inverse (k_i -> k_i-1) when dir=1.
module aes_key_step
  import aes_pkg::*;
(
  input  logic         dir,
  input  logic [7:0]   rcon,
  input  logic [127:0] rk_in,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g_in, g_out;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_in;
  // Both directions feed SubWord(RotWord()) from the new w3, so one S-box row is shared.
  assign g_in  = dir ? (w3 ^ w2) : w3;
  assign g_out = sub_word(rot_word(g_in)) ^ {rcon, 24'h000000};

  // Word recurrences for the selected direction.
  always_comb begin
    n0 = w0 ^ g_out;
    if (dir) begin
      n1 = w1 ^ w0;
      n2 = w2 ^ w1;
      n3 = w3 ^ w2;
    end else begin
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end
  end

  assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_inv_core_iter.sv
// Iterative AES-128 decryptor, one round per clock, key schedule run forward to k10 then backward.
// Define AES_KEY_CACHE_EN to cache the last key and its k10 so a repeated key skips expansion.
module aes_inv_core_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_inv_core_iter: NR must be %0d for AES-128", AES_NR);
  end

  fsm_e       state_q, state_d;
  aes_block_t st_q, st_d;
  aes_block_t rk_q, rk_d;
  aes_block_t block_out_q, block_out_d;
  logic [3:0] rnd_q, rnd_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;

  logic       accept;
  logic       cache_hit;
  aes_block_t cached_k10;
  aes_block_t key_step;
  aes_block_t inv_sr_sb;
  logic       key_dir;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign block_out = block_out_q;

  assign key_dir   = (state_q != S_KEYEXP);
  assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(st_q));

  aes_key_step u_key_step (
    .dir    (key_dir),
    .rcon   (RCON[rnd_q]),
    .rk_in  (rk_q),
    .rk_out (key_step)
  );

`ifdef AES_KEY_CACHE_EN
  aes_block_t key_q, key_d;
  aes_block_t cache_key_q, cache_key_d;
  aes_block_t cache_k10_q, cache_k10_d;
  logic       cache_valid_q, cache_valid_d;

  assign cache_hit  = cache_valid_q && (key == cache_key_q);
  assign cached_k10 = cache_k10_q;

  // Hold the job key; publish key and k10 on the last forward step.
  always_comb begin
    key_d         = key_q;
    cache_key_d   = cache_key_q;
    cache_k10_d   = cache_k10_q;
    cache_valid_d = cache_valid_q;
    if ((state_q == S_IDLE) && accept) begin
      key_d = key;
    end else begin
      key_d = key_q;
    end
    if ((state_q == S_KEYEXP) && (rnd_q == LAST_RND)) begin
      cache_key_d   = key_q;
      cache_k10_d   = key_step;
      cache_valid_d = 1'b1;
    end else begin
      cache_valid_d = cache_valid_q;
    end
  end

  // Cache registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q         <= 128'd0;
      cache_key_q   <= 128'd0;
      cache_k10_q   <= 128'd0;
      cache_valid_q <= 1'b0;
    end else begin
      key_q         <= key_d;
      cache_key_q   <= cache_key_d;
      cache_k10_q   <= cache_k10_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cached_k10 = 128'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = cache_hit ? S_ADDKEY : S_KEYEXP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KEYEXP: begin
        if (rnd_q == LAST_RND) begin
          state_d = S_ADDKEY;
        end else begin
          state_d = S_KEYEXP;
        end
      end
      S_ADDKEY: state_d = S_ROUND;
      S_ROUND: begin
        if (rnd_q == 4'd1) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the upcoming state so they change on the same edge.
  always_comb begin
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath: block state, round key and round counter.
  always_comb begin
    st_d        = st_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    block_out_d = block_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          st_d  = block_in;
          rk_d  = cache_hit ? cached_k10 : key;
          rnd_d = cache_hit ? LAST_RND : 4'd1;
        end else begin
          st_d = st_q;
        end
      end
      S_KEYEXP: begin
        rk_d = key_step;
        if (rnd_q != LAST_RND) begin
          rnd_d = rnd_q + 4'd1;
        end else begin
          rnd_d = rnd_q;
        end
      end
      S_ADDKEY: begin
        st_d  = st_q ^ rk_q;
        rk_d  = key_step;
        rnd_d = LAST_RND - 4'd1;
      end
      S_ROUND: begin
        st_d  = inv_mix_columns(inv_sr_sb ^ rk_q);
        rk_d  = key_step;
        rnd_d = rnd_q - 4'd1;
      end
      S_FINAL: block_out_d = inv_sr_sb ^ rk_q;
      default: block_out_d = block_out_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= 128'd0;
      rk_q        <= 128'd0;
      rnd_q       <= 4'd0;
      block_out_q <= 128'd0;
    end else begin
      st_q        <= st_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      block_out_q <= block_out_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_core_iter.sv
// Self-checking bench for aes_inv_core_iter: FIPS vectors, backpressure, abort, back-to-back and
// random round-trips through an independent forward-cipher model (sbox derived from GF(2^8)).
module tb_aes_inv_core_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] block_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] block_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q [$];
  int           lat_q [$];
  logic [7:0]   sb [256];
  logic         m_cv = 1'b0;
  logic [127:0] m_ck = 128'd0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_core_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .block_in  (block_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_out (block_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] enc(logic [127:0] k, logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[4*(((i/4) + (i%4)) % 4) + (i%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Wait for in_ready, present one job for a single cycle, then scramble the inputs.
  task automatic start_job(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input bit track);
    int guard;
    int lat;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    key      = k;
    block_in = ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    key      = ~k;
    block_in = ~ct;
    if (track) begin
`ifdef AES_KEY_CACHE_EN
      lat  = (m_cv && (m_ck == k)) ? 11 : 21;
      m_cv = 1'b1;
      m_ck = k;
`else
      lat = 21;
`endif
      exp_q.push_back(pt);
      lat_q.push_back(lat);
    end
  endtask

  // Pop the scoreboard, wait for the result, optionally stall, then complete the handshake.
  task automatic finish_job(input int stall, input bit early);
    logic [127:0] exp_pt;
    int           exp_lat;
    int           n;
    exp_pt    = exp_q.pop_front();
    exp_lat   = lat_q.pop_front();
    n         = 0;
    out_ready = early;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != exp_lat) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required %0d", n, exp_lat);
    end
    n_checks++;
    if (block_out !== exp_pt) begin
      n_fail++;
      $display("FAIL data: got %h required %h", block_out, exp_pt);
    end
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      key       = B_KEY;
      block_in  = B_CT;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || block_out !== exp_pt || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall: out_valid=%b in_ready=%b block_out=%h required 1 0 %h",
                 out_valid, in_ready, block_out, exp_pt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake: out_valid=%b busy=%b in_ready=%b required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = 128'd0;
    block_in  = 128'd0;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || block_out !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b block_out=%h required 0 0 0 0",
               in_ready, out_valid, busy, block_out);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_fips_c1();
    start_job(C1_KEY, C1_CT, C1_PT, 1'b1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_accept: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    finish_job(0, 1'b0);
  endtask

  task automatic test_fips_b();
    start_job(B_KEY, B_CT, B_PT, 1'b1);
    finish_job(0, 1'b0);
  endtask

  task automatic test_backpressure();
    start_job(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_job(5, 1'b0);
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_in_valid: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    start_job(B_KEY, B_CT, B_PT, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    m_cv = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || block_out !== 128'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: out_valid=%b block_out=%h in_ready=%b busy=%b required 0 0 1 0",
               out_valid, block_out, in_ready, busy);
    end
    start_job(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_job(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_job(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_job(0, 1'b1);
    start_job(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_job(0, 1'b1);
    start_job(B_KEY, B_CT, B_PT, 1'b1);
    finish_job(0, 1'b1);
  endtask

  task automatic test_roundtrip();
    logic [127:0] k, pt;
    for (int j = 0; j < 200; j++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_job(k, enc(k, pt), pt, 1'b1);
      finish_job(0, 1'b1);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
